sdram_arbiter: RTL and testbench

Two-master arbiter between the L1 instruction cache and the L1 data cache on one side and the single SDRAM controller bus on the other. It serialises level-held start/done transactions from both caches onto the controller, latches the winning master's request, and routes the read word and completion pulse back to that master only. It sits directly downstream of both L1 cache instances.

---
 rtl/sdram_arb_pkg.sv | 25 ++
 rtl/sdram_arb_port.sv | 58 +++++
 rtl/sdram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared state encodings and master IDs for the SDRAM arbiter.
// Revision : 1.0
// ============================================================================
package sdram_arb_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic MASTER_I = 1'b0;
    localparam logic MASTER_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_GRANT_I = GRANT_I,
        ST_GRANT_D = GRANT_D,
        ST_RELEASE = RELEASE
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_port.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_port
// Brief    : Per-master drop-flag, request eligibility and response registers.
// Revision : 1.0
// ============================================================================
module sdram_arb_port
    import sdram_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              complete,
    input  logic [DATA_W-1:0] sdc_q,
    output logic              eligible,
    output logic [DATA_W-1:0] q,
    output logic              done
);

    logic              drop_q, drop_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              done_q, done_d;

    // A start still held after completion must be seen low once before it
    // can count as a fresh request.
    always_comb begin
        drop_d = drop_q;
        q_d    = q_q;
        done_d = 1'b0;
        if (complete) begin
            drop_d = 1'b1;
            q_d    = sdc_q;
            done_d = 1'b1;
        end else if (!start) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_q <= 1'b0;
            q_q    <= '0;
            done_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
            q_q    <= q_d;
            done_q <= done_d;
        end
    end

    assign eligible = start & ~drop_q;
    assign q        = q_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Two-master (I-cache / D-cache) arbiter onto one SDRAM controller.
//            Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise
//            the data cache always wins a tie.
// Revision : 1.0
// ============================================================================
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_start,
    output logic [DATA_W-1:0] i_q,
    output logic              i_done,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_we,
    input  logic              d_start,
    output logic [DATA_W-1:0] d_q,
    output logic              d_done,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data,
    output logic              sdc_we,
    output logic              sdc_start,
    input  logic [DATA_W-1:0] sdc_q,
    input  logic              sdc_done
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] sdc_addr_q, sdc_addr_d;
    logic [DATA_W-1:0] sdc_data_q, sdc_data_d;
    logic              sdc_we_q, sdc_we_d;
    logic              sdc_start_q, sdc_start_d;
    logic              i_elig, d_elig;
    logic              i_complete, d_complete;
    logic              d_wins_tie, pick_d;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    assign d_wins_tie = (last_q == MASTER_I);

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= MASTER_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign d_wins_tie = 1'b1;
`endif

    assign pick_d = d_elig & (~i_elig | d_wins_tie);

    always_comb begin
        state_d     = state_q;
        sdc_addr_d  = sdc_addr_q;
        sdc_data_d  = sdc_data_q;
        sdc_we_d    = sdc_we_q;
        sdc_start_d = sdc_start_q;
        i_complete  = 1'b0;
        d_complete  = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_elig || d_elig) begin
                    sdc_start_d = 1'b1;
                    if (pick_d) begin
                        sdc_addr_d = d_addr;
                        sdc_data_d = d_data;
                        sdc_we_d   = d_we;
                        state_d    = ST_GRANT_D;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                        last_d     = MASTER_D;
`endif
                    end else begin
                        sdc_addr_d = i_addr;
                        sdc_data_d = i_data;
                        sdc_we_d   = i_we;
                        state_d    = ST_GRANT_I;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                        last_d     = MASTER_I;
`endif
                    end
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (sdc_done) begin
                    i_complete  = (state_q == ST_GRANT_I);
                    d_complete  = (state_q == ST_GRANT_D);
                    sdc_addr_d  = '0;
                    sdc_data_d  = '0;
                    sdc_we_d    = 1'b0;
                    sdc_start_d = 1'b0;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sdc_addr_q  <= '0;
            sdc_data_q  <= '0;
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sdc_addr_q  <= sdc_addr_d;
            sdc_data_q  <= sdc_data_d;
            sdc_we_q    <= sdc_we_d;
            sdc_start_q <= sdc_start_d;
        end
    end

    sdram_arb_port #(.DATA_W(DATA_W)) u_port_i (
        .clk      (clk),
        .reset    (reset),
        .start    (i_start),
        .complete (i_complete),
        .sdc_q    (sdc_q),
        .eligible (i_elig),
        .q        (i_q),
        .done     (i_done)
    );

    sdram_arb_port #(.DATA_W(DATA_W)) u_port_d (
        .clk      (clk),
        .reset    (reset),
        .start    (d_start),
        .complete (d_complete),
        .sdc_q    (sdc_q),
        .eligible (d_elig),
        .q        (d_q),
        .done     (d_done)
    );

    assign sdc_addr  = sdc_addr_q;
    assign sdc_data  = sdc_data_q;
    assign sdc_we    = sdc_we_q;
    assign sdc_start = sdc_start_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Brief    : Scoreboard bench for sdram_arbiter with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_sdram_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_addr, i_data, d_addr, d_data;
    logic        i_we, i_start, d_we, d_start;
    logic [31:0] i_q, d_q;
    logic        i_done, d_done;
    logic [31:0] sdc_addr, sdc_data;
    logic        sdc_we, sdc_start;
    logic [31:0] sdc_q;
    logic        sdc_done;

    typedef struct {logic [31:0] addr; logic [31:0] data; logic we;} req_t;
    typedef struct {logic id; logic [31:0] q;} rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    sdram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_data(i_data), .i_we(i_we), .i_start(i_start),
        .i_q(i_q), .i_done(i_done),
        .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_start(d_start),
        .d_q(d_q), .d_done(d_done),
        .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we),
        .sdc_start(sdc_start), .sdc_q(sdc_q), .sdc_done(sdc_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Request monitor: every rising sdc_start must match the next expected request.
    logic prev_start = 1'b0;
    int   lowcnt     = 99;
    req_t cur;
    always @(negedge clk) begin
        if (sdc_start && !prev_start) begin
            check("sdc_start gap>=2", 32'(lowcnt >= 2), 32'd1);
            if (exp_req.size() == 0) begin
                flag("unexpected sdc_start");
            end else begin
                cur = exp_req.pop_front();
                check("sdc_addr", sdc_addr, cur.addr);
                check("sdc_data", sdc_data, cur.data);
                check("sdc_we", 32'(sdc_we), 32'(cur.we));
            end
        end else if (sdc_start) begin
            check("sdc_addr hold", sdc_addr, cur.addr);
            check("sdc_we hold", 32'(sdc_we), 32'(cur.we));
        end else if (prev_start) begin
            check("sdc_addr cleared", sdc_addr, 32'h0);
            check("sdc_data cleared", sdc_data, 32'h0);
            check("sdc_we cleared", 32'(sdc_we), 32'h0);
        end
        lowcnt     = sdc_start ? 0 : lowcnt + 1;
        prev_start = sdc_start;
    end

    // Response monitor: done pulses pop the response scoreboard.
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
    rsp_t        r;
    always @(negedge clk) begin
        if (!reset) begin
            last_i = '0;
            last_d = '0;
        end else if (i_done || d_done) begin
            if (i_done && d_done) begin
                flag("both done together");
            end else if (exp_rsp.size() == 0) begin
                flag("unexpected done");
            end else begin
                r = exp_rsp.pop_front();
                check("done master id", 32'(d_done), 32'(r.id));
                check("response q", d_done ? d_q : i_q, r.q);
                if (d_done) begin
                    last_d = d_q;
                    check("i_q holds", i_q, last_i);
                end else begin
                    last_i = i_q;
                    check("d_q holds", d_q, last_d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int st);
        st = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sdc_start) begin
                st = cyc;
                break;
            end
        end
        if (st < 0) flag("sdc_start timeout");
    endtask

    // Controller model: answer lat cycles after sdc_start is first seen.
    task automatic serve(input int lat, input logic [31:0] qw, output int st);
        wait_start(st);
        if (st >= 0) begin
            repeat (lat) tick();
            sdc_done = 1'b1;
            sdc_q    = qw;
            tick();
            sdc_done = 1'b0;
            sdc_q    = 32'hFFFF_0000;
        end
    endtask

    // which: 0 = I, 1 = D, 2 = either
    task automatic wait_done(input int which, output int at, output logic id);
        at = -1;
        id = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((which != 1 && i_done) || (which != 0 && d_done)) begin
                at = cyc;
                id = d_done;
                break;
            end
        end
        if (at < 0) flag("done timeout");
    endtask

    function automatic req_t mk_req(input logic [31:0] a, input logic [31:0] dt, input logic we);
        req_t t;
        t.addr = a;
        t.data = dt;
        t.we   = we;
        return t;
    endfunction

    function automatic rsp_t mk_rsp(input logic id, input logic [31:0] q);
        rsp_t t;
        t.id = id;
        t.q  = q;
        return t;
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, st, at;
        logic id;
        bit   d_again;
        i_addr = '0; i_data = '0; i_we = 1'b0; i_start = 1'b0;
        d_addr = '0; d_data = '0; d_we = 1'b0; d_start = 1'b0;
        sdc_q = '0; sdc_done = 1'b0;

        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        check("reset sdc_start", 32'(sdc_start), 32'h0);
        check("reset sdc_addr", sdc_addr, 32'h0);
        check("reset sdc_data", sdc_data, 32'h0);
        check("reset sdc_we", 32'(sdc_we), 32'h0);
        check("reset i_q", i_q, 32'h0);
        check("reset d_q", d_q, 32'h0);
        check("reset i_done", 32'(i_done), 32'h0);
        check("reset d_done", 32'(d_done), 32'h0);

        // Single I read with 5-cycle controller latency
        tick();
        t0 = cyc;
        i_addr = 32'h0000_0123; i_start = 1'b1;
        exp_req.push_back(mk_req(32'h123, 32'h0, 1'b0));
        exp_rsp.push_back(mk_rsp(1'b0, 32'hDEAD_BEEF));
        serve(5, 32'hDEAD_BEEF, st);
        check("t1 sdc_start cycle", st, t0 + 1);
        wait_done(0, at, id);
        check("t1 i_done cycle", at, t0 + 7);
        check("t1 d_done low", 32'(d_done), 32'h0);
        i_start = 1'b0;

        // D write
        tick();
        d_addr = 32'h40; d_data = 32'h1234_5678; d_we = 1'b1; d_start = 1'b1;
        exp_req.push_back(mk_req(32'h40, 32'h1234_5678, 1'b1));
        exp_rsp.push_back(mk_rsp(1'b1, 32'h0BAD_F00D));
        serve(3, 32'h0BAD_F00D, st);
        wait_done(1, at, id);
        d_start = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("t2 sdc_we after", 32'(sdc_we), 32'h0);
        check("t2 sdc_start after", 32'(sdc_start), 32'h0);
        check("t2 d_done single pulse", 32'(d_done), 32'h0);

        // Simultaneous requests from reset, D re-requests once
        tick(); reset = 1'b0;
        tick(); reset = 1'b1;
        tick();
        i_addr = 32'h100; i_we = 1'b0; i_start = 1'b1;
        d_addr = 32'h200; d_we = 1'b0; d_data = 32'h0; d_start = 1'b1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        exp_req.push_back(mk_req(32'h200, 32'h0, 1'b0));
        exp_req.push_back(mk_req(32'h100, 32'h0, 1'b0));
        exp_req.push_back(mk_req(32'h204, 32'h0, 1'b0));
        exp_rsp.push_back(mk_rsp(1'b1, 32'hA000_0001));
        exp_rsp.push_back(mk_rsp(1'b0, 32'hA000_0002));
        exp_rsp.push_back(mk_rsp(1'b1, 32'hA000_0003));
`else
        exp_req.push_back(mk_req(32'h200, 32'h0, 1'b0));
        exp_req.push_back(mk_req(32'h204, 32'h0, 1'b0));
        exp_req.push_back(mk_req(32'h100, 32'h0, 1'b0));
        exp_rsp.push_back(mk_rsp(1'b1, 32'hA000_0001));
        exp_rsp.push_back(mk_rsp(1'b1, 32'hA000_0002));
        exp_rsp.push_back(mk_rsp(1'b0, 32'hA000_0003));
`endif
        d_again = 1'b0;
        for (int k = 0; k < 3; k++) begin
            serve(2, 32'hA000_0001 + 32'(k), st);
            wait_done(2, at, id);
            if (id && !d_again) begin
                d_start = 1'b0;
                tick();
                d_addr  = 32'h204;
                d_start = 1'b1;
                d_again = 1'b1;
            end else if (id) begin
                d_start = 1'b0;
            end else begin
                i_start = 1'b0;
            end
        end

        // Start held 3 cycles past done must not restart
        tick();
        i_addr = 32'h300; i_start = 1'b1;
        exp_req.push_back(mk_req(32'h300, 32'h0, 1'b0));
        exp_rsp.push_back(mk_rsp(1'b0, 32'hC0FF_EE01));
        serve(2, 32'hC0FF_EE01, st);
        wait_done(0, at, id);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4 no restart while held", 32'(sdc_start), 32'h0);
        end
        i_start = 1'b0;
        tick();
        i_addr = 32'h304; i_start = 1'b1;
        exp_req.push_back(mk_req(32'h304, 32'h0, 1'b0));
        exp_rsp.push_back(mk_rsp(1'b0, 32'hC0FF_EE02));
        serve(2, 32'hC0FF_EE02, st);
        wait_done(0, at, id);
        i_start = 1'b0;

        // Reset during GRANT_I with a late controller done
        tick();
        i_addr = 32'h400; i_start = 1'b1;
        exp_req.push_back(mk_req(32'h400, 32'h0, 1'b0));
        wait_start(st);
        tick(); reset = 1'b0; i_start = 1'b0;
        tick(); reset = 1'b1;
        @(negedge clk);
        check("t5 sdc_start", 32'(sdc_start), 32'h0);
        check("t5 sdc_addr", sdc_addr, 32'h0);
        check("t5 i_q", i_q, 32'h0);
        check("t5 d_q", d_q, 32'h0);
        check("t5 i_done", 32'(i_done), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            sdc_done = (k == 1);
            sdc_q    = 32'hBAD0_0BAD;
            @(negedge clk);
            check("t5 no i_done", 32'(i_done), 32'h0);
            check("t5 no sdc_start", 32'(sdc_start), 32'h0);
        end

        // Back-to-back D requests; first one also proves IDLE after reset
        tick();
        t0 = cyc;
        d_addr = 32'h500; d_data = 32'hAAAA_5555; d_we = 1'b1; d_start = 1'b1;
        exp_req.push_back(mk_req(32'h500, 32'hAAAA_5555, 1'b1));
        exp_rsp.push_back(mk_rsp(1'b1, 32'h1111_1111));
        serve(2, 32'h1111_1111, st);
        check("t6 first start cycle", st, t0 + 1);
        wait_done(1, at, id);
        d_start = 1'b0;
        tick();
        d_addr = 32'h504; d_data = 32'h0; d_we = 1'b0; d_start = 1'b1;
        exp_req.push_back(mk_req(32'h504, 32'h0, 1'b0));
        exp_rsp.push_back(mk_rsp(1'b1, 32'h2222_2222));
        serve(2, 32'h2222_2222, st);
        check("t6 restart cycle", st, at + 2);
        wait_done(1, at, id);
        d_start = 1'b0;

        repeat (4) tick();
        check("request queue drained", 32'(exp_req.size()), 32'h0);
        check("response queue drained", 32'(exp_rsp.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
